// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request, memory-port and response signals of the load/store unit controller
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        rd_en;
  logic [63:0] rd_addr;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [63:0] wr_data;
  logic [3:0]  wr_mask;
  logic        wr_finish;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_signed,
           rd_valid, rd_data, wr_finish, resp_ready,
    output req_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_mask,
           resp_valid, resp_rdata, resp_err, busy
  );
  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_signed,
           rd_valid, rd_data, wr_finish, resp_ready,
    input  req_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_mask,
           resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller with alignment check, extension and wait timeout
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic       clock,
  input logic       reset,
  lsu_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;
  state_t      state;
  logic [63:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        signed_q, err_q;
  logic [7:0]  cnt;
  logic [2:0]  low_mask;
  logic        misaligned;
  logic [63:0] req_mask, ext_data, d;
  logic        s;
  always_comb begin
    low_mask   = bus.req_size == 2'd0 ? 3'd0 : bus.req_size == 2'd1 ? 3'd1 :
                 bus.req_size == 2'd2 ? 3'd3 : 3'd7;
    misaligned = |(bus.req_addr[2:0] & low_mask);
    req_mask   = bus.req_size == 2'd0 ? 64'hFF : bus.req_size == 2'd1 ? 64'hFFFF :
                 bus.req_size == 2'd2 ? 64'hFFFF_FFFF : '1;
    d          = bus.rd_data;
    s          = signed_q;
    ext_data   = size_q == 2'd0 ? {{56{s & d[7]}}, d[7:0]} :
                 size_q == 2'd1 ? {{48{s & d[15]}}, d[15:0]} :
                 size_q == 2'd2 ? {{32{s & d[31]}}, d[31:0]} : d;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          addr_q   <= bus.req_addr;
          wdata_q  <= bus.req_wdata & req_mask;
          size_q   <= bus.req_size;
          signed_q <= bus.req_signed;
          rdata_q  <= '0;
          err_q    <= misaligned;
          cnt      <= '0;
          state    <= misaligned ? RESP : bus.req_wen ? WR_WAIT : RD_WAIT;
        end
        RD_WAIT: begin
          // completion takes priority over a timeout in the same cycle
          if (bus.rd_valid) begin
            rdata_q <= ext_data;
            state   <= RESP;
          end else if (cnt == 8'(TIMEOUT)) begin
            err_q <= 1'b1;
            state <= RESP;
          end else
            cnt <= cnt + 8'd1;
        end
        WR_WAIT: begin
          if (bus.wr_finish)
            state <= RESP;
          else if (cnt == 8'(TIMEOUT)) begin
            err_q <= 1'b1;
            state <= RESP;
          end else
            cnt <= cnt + 8'd1;
        end
        RESP: if (bus.resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.req_ready  = state == IDLE;
  assign bus.busy       = state != IDLE;
  assign bus.rd_en      = state == RD_WAIT;
  assign bus.rd_addr    = state == RD_WAIT ? addr_q : '0;
  assign bus.wr_en      = state == WR_WAIT;
  assign bus.wr_addr    = state == WR_WAIT ? addr_q : '0;
  assign bus.wr_data    = wdata_q;
  assign bus.wr_mask    = 4'b0001 << size_q;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vectors and multi-cycle sequences for lsu_ctrl
module tb_lsu_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  lsu_ctrl_if i0 ();
  lsu_ctrl_if i1 ();
  lsu_ctrl dut (.clock(clock), .reset(reset), .bus(i0));
  lsu_ctrl #(.TIMEOUT(4)) dut_t (.clock(clock), .reset(reset), .bus(i1));
  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] rdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    logic [63:0] exp_wdata;
    logic [3:0]  exp_mask;
  } vec_t;
  vec_t vecs[12];
  int n_chk = 0;
  int n_fail = 0;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [1:0] size, input logic sgn, input logic [63:0] rdata,
                              input logic [63:0] exp_rdata, input logic exp_err,
                              input logic [63:0] exp_wdata, input logic [3:0] exp_mask);
    vec_t v;
    v.wen = wen; v.addr = addr; v.wdata = wdata; v.size = size; v.sgn = sgn; v.rdata = rdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_wdata = exp_wdata; v.exp_mask = exp_mask;
    return v;
  endfunction
  task automatic issue0(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [1:0] size, input logic sgn);
    i0.req_valid = 1'b1; i0.req_wen = wen; i0.req_addr = addr;
    i0.req_wdata = wdata; i0.req_size = size; i0.req_signed = sgn;
    step();
    i0.req_valid = 1'b0;
  endtask
  task automatic run_vec(input int k, input vec_t v);
    string t;
    t = $sformatf("v%0d", k);
    issue0(v.wen, v.addr, v.wdata, v.size, v.sgn);
    if (v.exp_err) begin
      chk({t, " misaligned resp_valid"}, {63'd0, i0.resp_valid}, 64'd1);
      chk({t, " misaligned no enable"}, {62'd0, i0.rd_en, i0.wr_en}, 64'd0);
    end else begin
      chk({t, " enables"}, {62'd0, i0.rd_en, i0.wr_en}, v.wen ? 64'd1 : 64'd2);
      chk({t, " port addr"}, v.wen ? i0.wr_addr : i0.rd_addr, v.addr);
      if (v.wen) begin
        chk({t, " wr_data"}, i0.wr_data, v.exp_wdata);
        chk({t, " wr_mask"}, {60'd0, i0.wr_mask}, {60'd0, v.exp_mask});
      end
      i0.rd_valid = ~v.wen; i0.wr_finish = v.wen; i0.rd_data = v.rdata;
      step();
      i0.rd_valid = 1'b0; i0.wr_finish = 1'b0;
      chk({t, " resp_valid"}, {63'd0, i0.resp_valid}, 64'd1);
    end
    chk({t, " resp_rdata"}, i0.resp_rdata, v.exp_rdata);
    chk({t, " resp_err"}, {63'd0, i0.resp_err}, {63'd0, v.exp_err});
    i0.resp_ready = 1'b1;
    step();
    i0.resp_ready = 1'b0;
    chk({t, " back to idle"}, {62'd0, i0.req_ready, i0.busy}, 64'd2);
  endtask
  initial begin
    logic [63:0] held;
    vecs[0]  = mk(0, 64'h1003, 0, 2'd0, 1, 64'h1234_5678_90AB_CD80, 64'hFFFF_FFFF_FFFF_FF80, 0, 0, 0);
    vecs[1]  = mk(0, 64'h1003, 0, 2'd0, 0, 64'h1234_5678_90AB_CD80, 64'h80, 0, 0, 0);
    vecs[2]  = mk(0, 64'h1004, 0, 2'd2, 0, 64'h0000_0000_8000_0001, 64'h8000_0001, 0, 0, 0);
    vecs[3]  = mk(0, 64'h1004, 0, 2'd2, 1, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_8000_0001, 0, 0, 0);
    vecs[4]  = mk(0, 64'h0010, 0, 2'd1, 1, 64'hAAAA_BBBB_CCCC_7FFF, 64'h7FFF, 0, 0, 0);
    vecs[5]  = mk(0, 64'h0018, 0, 2'd3, 1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 0, 0, 0);
    vecs[6]  = mk(1, 64'h2008, 64'h1122_3344_5566_7788, 2'd2, 0, 0, 0, 0, 64'h5566_7788, 4'b0100);
    vecs[7]  = mk(1, 64'h2001, 64'hFFFF, 2'd0, 0, 0, 0, 0, 64'hFF, 4'b0001);
    vecs[8]  = mk(1, 64'h2010, 64'hDEAD_BEEF_CAFE_F00D, 2'd3, 0, 0, 0, 0, 64'hDEAD_BEEF_CAFE_F00D, 4'b1000);
    vecs[9]  = mk(0, 64'h1002, 0, 2'd2, 0, 64'hFF, 0, 1, 0, 0);
    vecs[10] = mk(1, 64'h2001, 64'h1234, 2'd1, 0, 0, 0, 1, 0, 0);
    vecs[11] = mk(0, 64'h1004, 0, 2'd3, 1, 64'hFF, 0, 1, 0, 0);
    {i0.req_valid, i0.req_wen, i0.req_signed, i0.rd_valid, i0.wr_finish, i0.resp_ready} = '0;
    {i0.req_addr, i0.req_wdata, i0.rd_data, i0.req_size} = '0;
    {i1.req_valid, i1.req_wen, i1.req_signed, i1.rd_valid, i1.wr_finish, i1.resp_ready} = '0;
    {i1.req_addr, i1.req_wdata, i1.rd_data, i1.req_size} = '0;
    step(); step();
    reset = 1'b0;
    chk("reset req_ready/busy", {62'd0, i0.req_ready, i0.busy}, 64'd2);
    chk("reset enables/resp_valid", {61'd0, i0.rd_en, i0.wr_en, i0.resp_valid}, 64'd0);
    chk("reset resp_rdata", i0.resp_rdata, 64'd0);
    // stray completions while idle must not start anything
    i0.rd_valid = 1'b1; i0.wr_finish = 1'b1;
    step();
    i0.rd_valid = 1'b0; i0.wr_finish = 1'b0;
    chk("idle ignores completions", {62'd0, i0.busy, i0.resp_valid}, 64'd0);
    for (int k = 0; k < 12; k++) run_vec(k, vecs[k]);
    // store with wr_finish delayed 5 cycles, stray rd_valid ignored
    issue0(1'b1, 64'h2000, 64'hDEAD_BEEF, 2'd1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("store wr_en c%0d", k + 1), {62'd0, i0.wr_en, i0.resp_valid}, 64'd2);
      chk($sformatf("store wr_data c%0d", k + 1), i0.wr_data, 64'hBEEF);
      chk($sformatf("store wr_mask c%0d", k + 1), {60'd0, i0.wr_mask}, 64'b0010);
      i0.rd_valid = (k == 1);
      step();
      i0.rd_valid = 1'b0;
    end
    chk("store wr_en c6", {63'd0, i0.wr_en}, 64'd1);
    i0.wr_finish = 1'b1;
    step();
    i0.wr_finish = 1'b0;
    chk("store resp", {61'd0, i0.resp_valid, i0.wr_en, i0.resp_err}, 64'd4);
    chk("store resp_rdata", i0.resp_rdata, 64'd0);
    i0.resp_ready = 1'b1; step(); i0.resp_ready = 1'b0;
    // response holdoff: data stable and no acceptance while RESP is pending
    issue0(1'b0, 64'h40, 64'd0, 2'd3, 1'b0);
    i0.rd_valid = 1'b1; i0.wr_finish = 1'b1; i0.rd_data = 64'h0123_4567_89AB_CDEF;
    step();
    i0.rd_valid = 1'b0; i0.wr_finish = 1'b0; i0.rd_data = 64'hFFFF;
    held = i0.resp_rdata;
    chk("load before holdoff", held, 64'h0123_4567_89AB_CDEF);
    i0.req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("holdoff c%0d valid/ready", k), {62'd0, i0.resp_valid, i0.req_ready}, 64'd2);
      chk($sformatf("holdoff c%0d rdata", k), i0.resp_rdata, held);
      step();
    end
    i0.req_valid = 1'b0;
    i0.resp_ready = 1'b1; step(); i0.resp_ready = 1'b0;
    chk("holdoff released", {62'd0, i0.req_ready, i0.resp_valid}, 64'd2);
    // timeout with no rd_valid (TIMEOUT=4)
    i1.req_valid = 1'b1; i1.req_wen = 1'b0; i1.req_addr = 64'h8; i1.req_size = 2'd3;
    step();
    i1.req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("timeout wait c%0d", k), {62'd0, i1.rd_en, i1.resp_valid}, 64'd2);
      step();
    end
    chk("timeout resp", {61'd0, i1.resp_valid, i1.rd_en, i1.resp_err}, 64'd5);
    chk("timeout rdata", i1.resp_rdata, 64'd0);
    i1.resp_ready = 1'b1; step(); i1.resp_ready = 1'b0;
    // completion on the timeout cycle wins
    i1.req_valid = 1'b1;
    step();
    i1.req_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("late wait still enabled", {63'd0, i1.rd_en}, 64'd1);
    i1.rd_valid = 1'b1; i1.rd_data = 64'h55;
    step();
    i1.rd_valid = 1'b0;
    chk("late completion resp", {62'd0, i1.resp_valid, i1.resp_err}, 64'd2);
    chk("late completion rdata", i1.resp_rdata, 64'h55);
    i1.resp_ready = 1'b1; step(); i1.resp_ready = 1'b0;
    // reset during WR_WAIT aborts with no response
    issue0(1'b1, 64'h3000, 64'h77, 2'd0, 1'b0);
    step();
    chk("pre-reset wr_en", {63'd0, i0.wr_en}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("post-reset state", {60'd0, i0.req_ready, i0.busy, i0.wr_en, i0.resp_valid}, 64'd8);
    i0.wr_finish = 1'b1;
    step();
    i0.wr_finish = 1'b0;
    step();
    chk("post-reset no response", {62'd0, i0.resp_valid, i0.busy}, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
